// File: rtl/tetris_board_if.sv
// Bus between the falling-piece logic and the board: four square pixel positions
// and the lock strobe in, occupancy and sequence status out.
interface tetris_board_if #(
  parameter int ROWS = 20,
  parameter int COLS = 10
);
  logic [9:0]           square1x, square2x, square3x, square4x;
  logic [9:0]           square1y, square2y, square3y, square4y;
  logic                 at_bottom;
  logic [ROWS*COLS-1:0] board;
  logic                 busy;
  logic                 done;
  logic [2:0]           lines_last;
  logic [15:0]          lines_total;
  logic                 oob_err;
  logic                 lock_drop;
`ifdef TETRIS_BOARD_GAMEOVER_EN
  logic                 game_over;

  modport slave (
    input  square1x, square2x, square3x, square4x,
    input  square1y, square2y, square3y, square4y,
    input  at_bottom,
    output board, busy, done, lines_last, lines_total, oob_err, lock_drop, game_over
  );
  modport master (
    output square1x, square2x, square3x, square4x,
    output square1y, square2y, square3y, square4y,
    output at_bottom,
    input  board, busy, done, lines_last, lines_total, oob_err, lock_drop, game_over
  );
`else
  modport slave (
    input  square1x, square2x, square3x, square4x,
    input  square1y, square2y, square3y, square4y,
    input  at_bottom,
    output board, busy, done, lines_last, lines_total, oob_err, lock_drop
  );
  modport master (
    output square1x, square2x, square3x, square4x,
    output square1y, square2y, square3y, square4y,
    output at_bottom,
    input  board, busy, done, lines_last, lines_total, oob_err, lock_drop
  );
`endif
endinterface

// File: rtl/tetris_board.sv
// Tetris playfield: locks a four-square piece, then scans bottom-up and collapses full rows.
// Optional sticky game-over flag is compiled in with TETRIS_BOARD_GAMEOVER_EN.
module tetris_board #(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int CELL_PX = 20,
  parameter int X_ORG   = 200,
  parameter int Y_ORG   = 0
) (
  input  logic          Clk,
  input  logic          Reset_n,
  tetris_board_if.slave bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);
  localparam int PTR_W = $clog2(ROWS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOCK  = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [CELLS-1:0]       board_q, board_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [2:0]             lines_last_q, lines_last_d;
  logic [15:0]            lines_total_q, lines_total_d;
  logic [3:0]             sq_oob_q, sq_oob_d;
  logic [3:0][IDX_W-1:0]  sq_idx_q, sq_idx_d;
  logic [3:0][9:0]        sq_x, sq_y;
  logic                   blocked;

  // Returns {out_of_board, cell_index}; index is zero when out of board.
  function automatic logic [IDX_W:0] map_square(input logic [9:0] px, input logic [9:0] py);
    int x, y, col, row;
    x = int'(px);
    y = int'(py);
    map_square = {1'b1, {IDX_W{1'b0}}};
    if (x >= X_ORG && y >= Y_ORG) begin
      col = (x - X_ORG) / CELL_PX;
      row = (y - Y_ORG) / CELL_PX;
      if (col < COLS && row < ROWS) map_square = {1'b0, IDX_W'(row * COLS + col)};
    end
  endfunction

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign sq_x = {bus.square4x, bus.square3x, bus.square2x, bus.square1x};
  assign sq_y = {bus.square4y, bus.square3y, bus.square2y, bus.square1y};

`ifdef TETRIS_BOARD_GAMEOVER_EN
  logic game_over_q, game_over_d;
  assign blocked       = game_over_q;
  assign bus.game_over = game_over_q;
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    ptr_d         = ptr_q;
    lines_last_d  = lines_last_q;
    lines_total_d = lines_total_q;
    sq_oob_d      = sq_oob_q;
    sq_idx_d      = sq_idx_q;
`ifdef TETRIS_BOARD_GAMEOVER_EN
    game_over_d   = game_over_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.at_bottom && !blocked) begin
          for (int i = 0; i < 4; i++) {sq_oob_d[i], sq_idx_d[i]} = map_square(sq_x[i], sq_y[i]);
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        for (int i = 0; i < 4; i++) if (!sq_oob_q[i]) board_d[sq_idx_q[i]] = 1'b1;
        ptr_d        = PTR_W'(ROWS - 1);
        lines_last_d = 3'd0;
        state_d      = S_SCAN;
      end
      S_SCAN: begin
        if (&board_q[int'(ptr_q)*COLS +: COLS]) state_d = S_SHIFT;
        else if (ptr_q == '0)                    state_d = S_DONE;
        else                                     ptr_d   = ptr_q - PTR_W'(1);
      end
      S_SHIFT: begin
        // Everything above the full row drops by one; the pointer stays so the new row is rescanned.
        for (int r = 1; r < ROWS; r++)
          if (r <= int'(ptr_q)) board_d[r*COLS +: COLS] = board_q[(r-1)*COLS +: COLS];
        board_d[COLS-1:0] = '0;
        lines_last_d  = sat_inc3(lines_last_q);
        lines_total_d = sat_inc16(lines_total_q);
        state_d       = S_SCAN;
      end
      S_DONE: begin
`ifdef TETRIS_BOARD_GAMEOVER_EN
        game_over_d = game_over_q | (|board_q[COLS-1:0]);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      board_q       <= '0;
      ptr_q         <= '0;
      lines_last_q  <= 3'd0;
      lines_total_q <= 16'd0;
      sq_oob_q      <= 4'd0;
`ifdef TETRIS_BOARD_GAMEOVER_EN
      game_over_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      ptr_q         <= ptr_d;
      lines_last_q  <= lines_last_d;
      lines_total_q <= lines_total_d;
      sq_oob_q      <= sq_oob_d;
`ifdef TETRIS_BOARD_GAMEOVER_EN
      game_over_q   <= game_over_d;
`endif
    end
  end

  // Cell indices are only consumed when the matching oob flag is clear, so they need no reset.
  always_ff @(posedge Clk) begin
    sq_idx_q <= sq_idx_d;
  end

  assign bus.board       = board_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.lines_last  = lines_last_q;
  assign bus.lines_total = lines_total_q;
  assign bus.oob_err     = (state_q == S_LOCK) && (|sq_oob_q);
  assign bus.lock_drop   = bus.at_bottom && ((state_q != S_IDLE) || blocked);
endmodule
